// File: rtl/psum_drain.sv
// psum_drain: realigns column-skewed psums into rows for the output writer.
// Optional: define PSUM_DRAIN_RELU_EN to clamp negative output lanes to zero.
module psum_drain #(
  parameter int COLS   = 4,
  parameter int DW     = 16,
  parameter int ROWS   = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [COLS*DW-1:0] psum_in,
  input  logic [COLS-1:0]   psum_vld,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COLS*DW-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [1:0]        state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(ROWS + 1) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e            state_q;
  logic [DW-1:0]     mem_q [DEPTH][COLS];
  logic [DEPTH-1:0]  occ_q;
  logic [PW-1:0]     wp_q [COLS];
  logic [PW-1:0]     rp_q;
  logic [CW-1:0]     dcnt_q [1:COLS-1];
  logic [RW-1:0]     rows_in_q;
  logic [ADDR_W-1:0] rows_out_q;
  logic [ADDR_W-1:0] base_q;
  logic              ovf_q;

  logic              xfer;
  logic              free0;
  logic [COLS-1:0]   wr;
  logic [COLS-1:0]   drop;

  // A free of lane 0's target entry in the same cycle lets the write land.
  always_comb begin
    xfer  = occ_q[rp_q] & out_ready;
    free0 = xfer && (rp_q == wp_q[0]);
    wr    = '0;
    drop  = '0;
    if (state_q == COLLECT) begin
      if (psum_vld[0]) begin
        if (occ_q[wp_q[0]] && !free0) drop[0] = 1'b1;
        else                          wr[0]   = 1'b1;
      end
      for (int c = 1; c < COLS; c++) begin
        if (psum_vld[c]) begin
          if (dcnt_q[c] != '0) drop[c] = 1'b1;
          else                 wr[c]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      occ_q      <= '0;
      rp_q       <= '0;
      rows_in_q  <= '0;
      rows_out_q <= '0;
      base_q     <= '0;
      ovf_q      <= 1'b0;
      for (int c = 0; c < COLS; c++) wp_q[c] <= '0;
      for (int c = 1; c < COLS; c++) dcnt_q[c] <= '0;
      for (int e = 0; e < DEPTH; e++)
        for (int c = 0; c < COLS; c++) mem_q[e][c] <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        if (wr[c]) begin
          mem_q[wp_q[c]][c] <= psum_in[c*DW +: DW];
          wp_q[c]           <= wp_q[c] + PW'(1);
        end
      end
      // Each lane inherits the drops of its left neighbour, one row at a time.
      for (int c = 1; c < COLS; c++)
        dcnt_q[c] <= dcnt_q[c] + CW'(drop[c-1]) - CW'(drop[c]);
      if (drop[0]) ovf_q <= 1'b1;
      if (xfer) begin
        occ_q[rp_q] <= 1'b0;
        rp_q        <= rp_q + PW'(1);
        rows_out_q  <= rows_out_q + ADDR_W'(1);
      end
      if (wr[COLS-1]) begin
        occ_q[wp_q[COLS-1]] <= 1'b1;
        rows_in_q           <= rows_in_q + RW'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= COLLECT;
            base_q     <= base_addr;
            rows_in_q  <= '0;
            rows_out_q <= '0;
            ovf_q      <= 1'b0;
            rp_q       <= '0;
            for (int c = 0; c < COLS; c++) wp_q[c] <= '0;
            for (int c = 1; c < COLS; c++) dcnt_q[c] <= '0;
          end
        end
        COLLECT: begin
          if (wr[COLS-1] && rows_in_q == RW'(ROWS - 1)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (occ_q == '0) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < COLS; c++) begin
`ifdef PSUM_DRAIN_RELU_EN
      out_data[c*DW +: DW] = mem_q[rp_q][c][DW-1] ? '0 : mem_q[rp_q][c];
`else
      out_data[c*DW +: DW] = mem_q[rp_q][c];
`endif
    end
  end

  assign out_valid = occ_q[rp_q];
  assign out_addr  = base_q + rows_out_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign overflow  = ovf_q;
  assign state     = state_q;

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: table of tiles plus reset and idle corner sequences,
// rows checked against a scoreboard queue filled when each tile starts.
module tb_psum_drain;
  localparam int COLS  = 4;
  localparam int DW    = 16;
  localparam int ROWS  = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [COLS*DW-1:0] psum_in = '0;
  logic [COLS-1:0] psum_vld = '0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [COLS*DW-1:0] out_data;
  logic [AW-1:0]   out_addr;
  logic            busy, done, overflow;
  logic [1:0]      state;

  psum_drain #(
    .COLS(COLS), .DW(DW), .ROWS(ROWS), .DEPTH(DEPTH), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .psum_in(psum_in), .psum_vld(psum_vld),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .done(done), .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] base;
    int nrows;
    int pat;
    int stall_t;
    int stall_len;
    int exp_rows;
    bit exp_ovf;
    bit inj_start;
  } tile_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [COLS*DW-1:0] data;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] val(input int pat, input int r,
                                        input int c);
    int v;
    if (pat == 0) v = 100 * r + c;
    else begin
      case (c)
        0: v = -5;
        1: v = 7;
        2: v = -1;
        default: v = 0;
      endcase
    end
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] model_out(input logic [DW-1:0] v);
`ifdef PSUM_DRAIN_RELU_EN
    if (v[DW-1]) return '0;
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mon_en && out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_row act=%h exp=none", out_addr);
      end else begin
        chk("row_addr", 64'(out_addr), 64'(sbq[0].addr));
        chk("row_data", 64'(out_data), 64'(sbq[0].data));
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  task automatic drive_feed(input tile_t tv, input int t);
    int r;
    psum_vld = '0;
    psum_in  = '0;
    for (int c = 0; c < COLS; c++) begin
      r = t - c;
      if (r >= 0 && r < tv.nrows) begin
        psum_vld[c] = 1'b1;
        psum_in[c*DW +: DW] = val(tv.pat, r, c);
      end
    end
  endtask

  task automatic run_tile(input tile_t tv);
    logic [COLS*DW-1:0] d;
    int t;
    bit seen;
    for (int r = 0; r < tv.exp_rows; r++) begin
      for (int c = 0; c < COLS; c++)
        d[c*DW +: DW] = model_out(val(tv.pat, r, c));
      sbq.push_back('{addr: AW'(tv.base + r), data: d});
    end
    done_cnt  = 0;
    base_addr = tv.base;
    start     = 1'b1;
    out_ready = 1'b1;
    psum_vld  = '0;
    @(posedge clk) #1;
    start = 1'b0;
    t = 0;
    seen = 1'b0;
    while (!seen && t < 400) begin
      drive_feed(tv, t);
      start     = tv.inj_start && (t == 2);
      base_addr = tv.inj_start ? 8'h55 : tv.base;
      out_ready = !(t >= tv.stall_t && t < tv.stall_t + tv.stall_len);
      @(negedge clk);
      chk("overflow", 64'(overflow), 64'(tv.exp_ovf && t > DEPTH));
      if (done) begin
        seen = 1'b1;
        chk("busy_at_done", 64'(busy), 64'd1);
      end
      @(posedge clk) #1;
      t++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout act=0 exp=1");
    end
    psum_vld  = '0;
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("busy_after", 64'(busy), 64'd0);
    chk("state_after", 64'(state), 64'd0);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("rows_left", 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  tile_t tiles[5];
  tile_t rt;

  initial begin
    tiles[0] = '{8'h10, 4, 0, -1, 0,  4, 1'b0, 1'b0};
    tiles[1] = '{8'h20, 4, 0,  5, 10, 4, 1'b0, 1'b0};
    tiles[2] = '{8'h30, 5, 0,  0, 20, 4, 1'b1, 1'b0};
    tiles[3] = '{8'hFE, 4, 0, -1, 0,  4, 1'b0, 1'b1};
    tiles[4] = '{8'h80, 4, 1, -1, 0,  4, 1'b0, 1'b0};

    #2 rst = 1'b0;
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", 64'(out_addr), 64'd0);
    #10 rst = 1'b1;

    @(posedge clk) #1;
    rt = '{8'h40, 4, 0, -1, 0, 0, 1'b0, 1'b0};
    done_cnt  = 0;
    base_addr = 8'h40;
    start     = 1'b1;
    out_ready = 1'b0;
    @(posedge clk) #1;
    start = 1'b0;
    for (int t = 0; t <= 4; t++) begin
      drive_feed(rt, t);
      if (t < 4) @(posedge clk) #1;
    end
    #2;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_addr", 64'(out_addr), 64'h40);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_addr", 64'(out_addr), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    chk("mid_rst_state", 64'(state), 64'd0);
    psum_vld = '0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    chk("mid_rst_no_done", 64'(done_cnt), 64'd0);

    mon_en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      psum_vld = '1;
      psum_in  = {$urandom, $urandom};
      @(negedge clk);
      chk("idle_valid", 64'(out_valid), 64'd0);
      chk("idle_state", 64'(state), 64'd0);
      @(posedge clk) #1;
    end
    psum_vld = '0;

    for (int i = 0; i < 5; i++) run_tile(tiles[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/psum_drain.md
Name: psum_drain

Overview:
- Output-side counterpart to the systolic-array input feeder.
- Collects partial-sum results that leave the bottom of the array skewed by column, one cycle per column.
- Reassembles them into aligned output rows and hands each row, with an output-buffer address, to the output memory writer over a valid/ready handshake.
- Sits between the PE array and the output buffer under the top-level controller.

Parameters:
COLS, 4, number of array columns (one psum lane each)
DW, 16, psum width in bits, two's complement
ROWS, 4, output rows per tile
DEPTH, 4, row reassembly buffer entries (power of 2)
ADDR_W, 8, output-buffer address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a tile
base_addr  in  ADDR_W  first output address, sampled on accepted start
psum_in  in  COLS*DW  lane c at bits [c*DW +: DW]
psum_vld  in  COLS  lane c carries a valid psum this cycle
out_valid  out  1  a complete row is presented
out_ready  in  1  output writer accepts row
out_data  out  COLS*DW  row data, same lane packing as psum_in
out_addr  out  ADDR_W  destination address of the presented row
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at tile end
overflow  out  1  sticky: psum dropped because the buffer was full
state  out  2  current FSM state, for debug

Behaviour:
- Reset (rst=0, asynchronous), all cleared: outputs 0, state=IDLE, pointers, counters, entry flags and overflow 0.
- FSM encoding: IDLE=0, COLLECT=1, DRAIN=2, DONE=3.
  - IDLE: start=1 latches base_addr and clears row counters and overflow, then goes to COLLECT. start is ignored in every other state.
  - COLLECT: psum_vld is accepted. When lane COLS-1 writes its ROWS-th row, go to DRAIN.
  - DRAIN: psum_vld is ignored. When the buffer is empty (no entry occupied), go to DONE.
  - DONE: done=1 for exactly this cycle, then IDLE.
- Buffer structure:
  - DEPTH entries, each holding COLS lanes and an occupied flag.
  - Each lane c has its own write pointer wp[c] (log2 DEPTH bits, wraps modulo DEPTH).
  - One shared read pointer rp.
- Lane writes: psum_vld[c] in COLLECT writes psum_in lane c into entry wp[c], then wp[c]++.
  - Lane 0 writing an entry that is still occupied drops that lane-0 psum, sets overflow=1 (sticky until the next accepted start), and does not advance wp[0].
  - Lanes c>0 that follow a dropped lane 0 are also dropped. A per-lane drop-count keeps them aligned.
- Row completion:
  - A lane COLS-1 write sets the entry's occupied flag and increments rows_in.
  - The skew guarantees lane COLS-1 is the last lane of each row.
- Output:
  - out_valid = occupied[rp], registered.
  - Latency: a lane COLS-1 write on cycle N gives out_valid=1 on cycle N+1.
  - out_data = entry rp.
  - out_addr = base_addr + rows_out, wrapping modulo 2^ADDR_W.
- Transfer: out_valid && out_ready clears occupied[rp], rp++, rows_out++.
  - out_data and out_addr stay stable while out_valid && !out_ready.
- Simultaneous events:
  - A transfer freeing entry E and a lane 0 write into E in the same cycle is not an overflow: the write succeeds and the free takes priority.
  - Occupied-set and clear target different entries when DEPTH>1.
- Output is not gated by state: rows drain during COLLECT as well as DRAIN.
- busy=1 in COLLECT, DRAIN and DONE.
- Reset mid-tile discards all buffered rows with no done pulse.

Optional Feature:
Macro: PSUM_DRAIN_RELU_EN.
- Defined: each out_data lane whose MSB is 1 (negative) is presented as 0; non-negative lanes pass unchanged. The function is applied on the output path, adds no latency, and leaves stored entries unmodified.
- Undefined: out_data is the raw psum.

Test Plan:
1. Reset: rst=0 asynchronously mid-cycle, with no clock edge -> all outputs 0 and state=0.
2. Basic tile, all parameters at defaults, out_ready=1, base_addr=8'h10, lane c values 100*r+c with skew c:
   - 4 rows emitted at addresses 0x10..0x13 with aligned data, e.g. row 2 = {203,202,201,200}.
   - done pulses once; busy falls on the following cycle.
3. Backpressure: hold out_ready=0 for 10 cycles during row 1 -> out_data and out_addr held stable, no loss, rows emitted in order once ready=1.
4. Overflow: DEPTH=4, out_ready=0 throughout, feed 5 rows -> overflow=1 at the first lane-0 drop, exactly 4 rows delivered after ready=1, tile still reaches DONE.
5. Wrap and ignore:
   - base_addr=8'hFE -> addresses FE, FF, 00, 01.
   - start asserted during COLLECT -> ignored.
   - psum_vld asserted in IDLE -> nothing written.
6. With PSUM_DRAIN_RELU_EN defined, row lanes {-5,7,-1,0} -> out_data {0,7,0,0}. Without the macro -> the raw values.
